cci_mpf_csr_mmio_responder: RTL and testbench
=============================================

// Module: cci_mpf_csr_mmio_responder
// PURPOSE
//   Manager end of the MPF CSR interface. Decodes host MMIO writes into VTP configuration outputs.
//   Accumulates VTP event pulses into counters and answers host MMIO reads.
//   Register sources for reads: DFH/UUID constants, VTP config, event counters, WRO statistics.
//   Sits between the CCI-P MMIO channels and the VTP/WRO shims; one instance per MPF.
// PARAMETERS
//   CSR_BASE_DW  16'h0000    DWORD base of the 32-DWORD CSR window; must be 32-DWORD aligned
//   DFH_VALUE    64'h0       value returned by register 0 (device feature header)
//   UUID_LO      64'h0       value returned by register 1
//   UUID_HI      64'h0       value returned by register 2
//   CL_ADDR_W    42          width of page-table base line address
//   CTR_W        48          event counter width; read back zero-extended to 64
// PORTS
//   clk               in   1          clock
//   reset             in   1          asynchronous, active-high reset
//   mmio_wr_valid     in   1          MMIO write request strobe
//   mmio_wr_addr      in   16         MMIO write DWORD address
//   mmio_wr_data      in   64         MMIO write data
//   mmio_rd_valid     in   1          MMIO read request strobe
//   mmio_rd_addr      in   16         MMIO read DWORD address
//   mmio_rd_tid       in   9          MMIO read transaction id
//   mmio_rsp_valid    out  1          read response strobe
//   mmio_rsp_tid      out  9          echoed tid
//   mmio_rsp_data     out  64         read data
//   vtp_mode          out  2          [0] VTP enable (level); [1] invalidate translation cache (1-cycle pulse)
//   vtp_pt_base       out  CL_ADDR_W  page-table base line address
//   vtp_pt_base_valid out  1          page-table base has been written
//   ev_4kb_hit, ev_4kb_miss, ev_2mb_hit, ev_2mb_miss, ev_pt_walk_busy
//                     in   1 each     single-cycle event / busy-level strobes from VTP
//   wro_num_writes, wro_num_reads, wro_num_wr_conflicts, wro_num_rd_conflicts
//                     in   64 each    WRO statistics
// BEHAVIOUR
//   Decode
//     - hit = addr[15:5]==CSR_BASE_DW[15:5] && addr[0]==0; index = addr[4:1].
//     - odd-DWORD or out-of-window: writes ignored; reads still answered with data 0.
//   Register map (64-bit; index)
//     - 0 DFH, 1 UUID_LO, 2 UUID_HI: RO
//     - 3 VTP_MODE: RW bit0; bit1 write-1 pulse, reads 0
//     - 4 PT_BASE: RW, data[CL_ADDR_W-1:0]
//     - 5 CTR_CLEAR: WO, write with bit0=1 clears indices 6..10; reads 0
//     - 6..10 counters: 4KB_HIT, 4KB_MISS, 2MB_HIT, 2MB_MISS, PT_WALK_BUSY (RO)
//     - 11..14 WRO writes/reads/wr_conf/rd_conf (RO pass-through)
//     - 15 reserved (reads 0). Writes to RO indices are ignored.
//   Writes
//     - write sampled at edge N takes effect on register outputs after edge N (visible cycle N+1).
//     - vtp_mode[1] is high exactly for cycle N+1, then 0; back-to-back pulse writes give back-to-back pulses.
//     - vtp_pt_base_valid goes 1 with the first PT_BASE write and stays 1 until reset.
//   Counters
//     - each counter +1 per cycle its strobe is high; wraps modulo 2^CTR_W.
//     - CTR_CLEAR in same cycle as an event: clear wins, that event is not counted.
//   Reads
//     - fully pipelined, accepts 1 request/cycle, fixed latency 2.
//     - request at edge N: tid/index registered at N; data muxed from register state after edge N and registered at N+1.
//     - mmio_rsp_valid high for cycle N+2 only; mmio_rsp_tid = request tid.
//     - read and write to the same index in the same cycle: read returns the new value.
//     - read of a counter returns its value including events up to and including cycle N.
//     - responses never reorder; no backpressure, no FIFO needed.
//     - WRO inputs are sampled in stage 2 (same timing as counters).
//   Reset
//     - all outputs 0, all counters 0, pipeline valids 0.
//     - reads in flight when reset asserts are dropped (no response).
//     - first request accepted on the first edge after reset deasserts.
// TESTING
//   1. After reset, read idx0/1/2 (tid 5,6,7) -> rsp at +2 cycles each, back-to-back; data DFH/UUID_LO/UUID_HI, tids 5,6,7.
//   2. Write PT_BASE=64'h3_0000_1234 -> next cycle vtp_pt_base=42'h3_0000_1234, valid=1.
//      Read idx4 -> same value; a later reset -> valid=0.
//   3. Write VTP_MODE=3 -> vtp_mode[0]=1 steady; vtp_mode[1]=1 for exactly one cycle. Read idx3 -> 64'h1.
//   4. Pulse ev_4kb_hit 10 cycles and ev_pt_walk_busy 7 cycles.
//      Read idx6 -> 10, idx10 -> 7. Then CTR_CLEAR with concurrent ev_4kb_hit -> idx6 reads 0.
//   5. Counter wrap: preload (force) CTR_W=8 build to 255, one ev_2mb_miss -> idx9 reads 0.
//   6. Edge access: read at odd DWORD addr, read at addr outside window, write to idx0.
//      -> both reads return 0 with correct tid; DFH unchanged.
//      Assert reset with 2 reads in flight -> no mmio_rsp_valid.

Source files
------------

// File: rtl/cci_mpf_csr_mmio_responder.sv
// MPF CSR manager: decodes host MMIO writes into VTP configuration, counts VTP
// events, and answers host MMIO reads with a fixed two-stage pipeline.
module cci_mpf_csr_mmio_responder #(
    parameter logic [15:0] CSR_BASE_DW = 16'h0000,
    parameter logic [63:0] DFH_VALUE   = 64'h0,
    parameter logic [63:0] UUID_LO     = 64'h0,
    parameter logic [63:0] UUID_HI     = 64'h0,
    parameter int unsigned CL_ADDR_W   = 42,
    parameter int unsigned CTR_W       = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mmio_wr_valid,
    input  logic [15:0]          mmio_wr_addr,
    input  logic [63:0]          mmio_wr_data,
    input  logic                 mmio_rd_valid,
    input  logic [15:0]          mmio_rd_addr,
    input  logic [8:0]           mmio_rd_tid,
    output logic                 mmio_rsp_valid,
    output logic [8:0]           mmio_rsp_tid,
    output logic [63:0]          mmio_rsp_data,
    output logic [1:0]           vtp_mode,
    output logic [CL_ADDR_W-1:0] vtp_pt_base,
    output logic                 vtp_pt_base_valid,
    input  logic                 ev_4kb_hit,
    input  logic                 ev_4kb_miss,
    input  logic                 ev_2mb_hit,
    input  logic                 ev_2mb_miss,
    input  logic                 ev_pt_walk_busy,
    input  logic [63:0]          wro_num_writes,
    input  logic [63:0]          wro_num_reads,
    input  logic [63:0]          wro_num_wr_conflicts,
    input  logic [63:0]          wro_num_rd_conflicts
);

    localparam int unsigned N_CTR = 5;
    localparam int unsigned IDX_W = 4;

    localparam logic [IDX_W-1:0] IDX_VTP_MODE  = 4'd3;
    localparam logic [IDX_W-1:0] IDX_PT_BASE   = 4'd4;
    localparam logic [IDX_W-1:0] IDX_CTR_CLEAR = 4'd5;

    logic             wr_hit_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             rd_hit_c;
    logic             ctr_clr_c;
    logic [N_CTR-1:0] ev_c;
    logic [63:0]      rd_data_c;
    logic             unused_wr_data;

    logic [CTR_W-1:0] ctr [N_CTR];

    logic             rd_v1;
    logic [8:0]       rd_tid1;
    logic [IDX_W-1:0] rd_idx1;
    logic             rd_hit1;

    // Window decode: 64-bit registers live at even DWORD addresses only.
    assign wr_hit_c  = mmio_wr_valid && (mmio_wr_addr[15:5] == CSR_BASE_DW[15:5]) && !mmio_wr_addr[0];
    assign wr_idx_c  = mmio_wr_addr[4:1];
    assign rd_hit_c  = (mmio_rd_addr[15:5] == CSR_BASE_DW[15:5]) && !mmio_rd_addr[0];
    assign ctr_clr_c = wr_hit_c && (wr_idx_c == IDX_CTR_CLEAR) && mmio_wr_data[0];
    assign ev_c      = {ev_pt_walk_busy, ev_2mb_miss, ev_2mb_hit, ev_4kb_miss, ev_4kb_hit};

    assign unused_wr_data = ^mmio_wr_data[63:CL_ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vtp_mode          <= 2'b00;
            vtp_pt_base       <= '0;
            vtp_pt_base_valid <= 1'b0;
        end else begin
            vtp_mode[1] <= wr_hit_c && (wr_idx_c == IDX_VTP_MODE) && mmio_wr_data[1];
            if (wr_hit_c && (wr_idx_c == IDX_VTP_MODE)) begin
                vtp_mode[0] <= mmio_wr_data[0];
            end
            if (wr_hit_c && (wr_idx_c == IDX_PT_BASE)) begin
                vtp_pt_base       <= mmio_wr_data[CL_ADDR_W-1:0];
                vtp_pt_base_valid <= 1'b1;
            end
        end
    end

    // Event counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CTR; i++) begin
                ctr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CTR; i++) begin
                if (ctr_clr_c) begin
                    ctr[i] <= '0;
                end else if (ev_c[i]) begin
                    ctr[i] <= ctr[i] + CTR_W'(1);
                end
            end
        end
    end

    // Read stage 1: capture request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1   <= 1'b0;
            rd_tid1 <= '0;
            rd_idx1 <= '0;
            rd_hit1 <= 1'b0;
        end else begin
            rd_v1   <= mmio_rd_valid;
            rd_tid1 <= mmio_rd_tid;
            rd_idx1 <= mmio_rd_addr[4:1];
            rd_hit1 <= rd_hit_c;
        end
    end

    // Read mux sees register state already updated by writes/events of the request cycle.
    always_comb begin
        rd_data_c = '0;
        if (rd_hit1) begin
            case (rd_idx1)
                4'd0:    rd_data_c = DFH_VALUE;
                4'd1:    rd_data_c = UUID_LO;
                4'd2:    rd_data_c = UUID_HI;
                4'd3:    rd_data_c = 64'(vtp_mode[0]);
                4'd4:    rd_data_c = 64'(vtp_pt_base);
                4'd6:    rd_data_c = 64'(ctr[0]);
                4'd7:    rd_data_c = 64'(ctr[1]);
                4'd8:    rd_data_c = 64'(ctr[2]);
                4'd9:    rd_data_c = 64'(ctr[3]);
                4'd10:   rd_data_c = 64'(ctr[4]);
                4'd11:   rd_data_c = wro_num_writes;
                4'd12:   rd_data_c = wro_num_reads;
                4'd13:   rd_data_c = wro_num_wr_conflicts;
                4'd14:   rd_data_c = wro_num_rd_conflicts;
                default: rd_data_c = '0;
            endcase
        end
    end

    // Read stage 2: response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= '0;
            mmio_rsp_data  <= '0;
        end else begin
            mmio_rsp_valid <= rd_v1;
            mmio_rsp_tid   <= rd_tid1;
            mmio_rsp_data  <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_cci_mpf_csr_mmio_responder.sv
// Directed bench for cci_mpf_csr_mmio_responder: register map, write side effects,
// counters (8-bit build for wrap), decode edges and reset behaviour.
module tb_cci_mpf_csr_mmio_responder;

    localparam logic [15:0] BASE   = 16'h0040;
    localparam logic [63:0] DFH    = 64'h1000_0000_0000_0A5A;
    localparam logic [63:0] ULO    = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] UHI    = 64'hFEED_FACE_89AB_CDEF;
    localparam int unsigned CLW    = 42;
    localparam int unsigned CTRW   = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           mmio_wr_valid;
    logic [15:0]    mmio_wr_addr;
    logic [63:0]    mmio_wr_data;
    logic           mmio_rd_valid;
    logic [15:0]    mmio_rd_addr;
    logic [8:0]     mmio_rd_tid;
    logic           mmio_rsp_valid;
    logic [8:0]     mmio_rsp_tid;
    logic [63:0]    mmio_rsp_data;
    logic [1:0]     vtp_mode;
    logic [CLW-1:0] vtp_pt_base;
    logic           vtp_pt_base_valid;
    logic           ev_4kb_hit, ev_4kb_miss, ev_2mb_hit, ev_2mb_miss, ev_pt_walk_busy;
    logic [63:0]    wro_num_writes, wro_num_reads, wro_num_wr_conflicts, wro_num_rd_conflicts;

    int errors = 0;
    int checks = 0;
    int rsp_seen;

    always #5 clk = ~clk;

    cci_mpf_csr_mmio_responder #(
        .CSR_BASE_DW(BASE),
        .DFH_VALUE  (DFH),
        .UUID_LO    (ULO),
        .UUID_HI    (UHI),
        .CL_ADDR_W  (CLW),
        .CTR_W      (CTRW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .mmio_wr_valid       (mmio_wr_valid),
        .mmio_wr_addr        (mmio_wr_addr),
        .mmio_wr_data        (mmio_wr_data),
        .mmio_rd_valid       (mmio_rd_valid),
        .mmio_rd_addr        (mmio_rd_addr),
        .mmio_rd_tid         (mmio_rd_tid),
        .mmio_rsp_valid      (mmio_rsp_valid),
        .mmio_rsp_tid        (mmio_rsp_tid),
        .mmio_rsp_data       (mmio_rsp_data),
        .vtp_mode            (vtp_mode),
        .vtp_pt_base         (vtp_pt_base),
        .vtp_pt_base_valid   (vtp_pt_base_valid),
        .ev_4kb_hit          (ev_4kb_hit),
        .ev_4kb_miss         (ev_4kb_miss),
        .ev_2mb_hit          (ev_2mb_hit),
        .ev_2mb_miss         (ev_2mb_miss),
        .ev_pt_walk_busy     (ev_pt_walk_busy),
        .wro_num_writes      (wro_num_writes),
        .wro_num_reads       (wro_num_reads),
        .wro_num_wr_conflicts(wro_num_wr_conflicts),
        .wro_num_rd_conflicts(wro_num_rd_conflicts)
    );

    function automatic logic [15:0] ra(input int unsigned idx);
        return BASE + 16'(idx * 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = a;
        mmio_wr_data  = d;
        tick();
        mmio_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] tid);
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = a;
        mmio_rd_tid   = tid;
    endtask

    task automatic check_rsp(input string tag, input logic [8:0] tid, input logic [63:0] exp);
        check({tag, "_vld"},  64'(mmio_rsp_valid), 64'd1);
        check({tag, "_tid"},  64'(mmio_rsp_tid),   64'(tid));
        check({tag, "_data"}, mmio_rsp_data,       exp);
    endtask

    // Issue one read and check its response two edges later.
    task automatic read_check(input string tag, input logic [15:0] a, input logic [8:0] tid,
                              input logic [63:0] exp);
        rd(a, tid);
        tick();
        mmio_rd_valid = 1'b0;
        tick();
        check_rsp(tag, tid, exp);
    endtask

    initial begin
        reset = 1'b1;
        mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0;
        mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0;
        ev_4kb_hit = 1'b0; ev_4kb_miss = 1'b0; ev_2mb_hit = 1'b0; ev_2mb_miss = 1'b0;
        ev_pt_walk_busy = 1'b0;
        wro_num_writes = 64'h0000_0001_0000_0011;
        wro_num_reads  = 64'h0000_0002_0000_0022;
        wro_num_wr_conflicts = 64'h8000_0000_0000_0033;
        wro_num_rd_conflicts = 64'h0000_0000_0000_0044;
        repeat (3) tick();
        check("rst_mode",   64'(vtp_mode),          64'd0);
        check("rst_ptbase", 64'(vtp_pt_base),       64'd0);
        check("rst_ptval",  64'(vtp_pt_base_valid), 64'd0);
        check("rst_rspv",   64'(mmio_rsp_valid),    64'd0);
        reset = 1'b0;

        // Back-to-back constant reads right after reset release
        rd(ra(0), 9'd5);
        tick();
        rd(ra(1), 9'd6);
        tick();
        check_rsp("b2b0", 9'd5, DFH);
        rd(ra(2), 9'd7);
        tick();
        check_rsp("b2b1", 9'd6, ULO);
        mmio_rd_valid = 1'b0;
        tick();
        check_rsp("b2b2", 9'd7, UHI);
        tick();
        check("b2b_idle", 64'(mmio_rsp_valid), 64'd0);

        // PT_BASE
        wr(ra(4), 64'h3_0000_1234);
        check("pt_base",  64'(vtp_pt_base),       64'h3_0000_1234);
        check("pt_valid", 64'(vtp_pt_base_valid), 64'd1);
        read_check("rd_pt", ra(4), 9'h011, 64'h3_0000_1234);
        // same-cycle write and read returns the new value; bits above 42 dropped
        mmio_wr_valid = 1'b1; mmio_wr_addr = ra(4); mmio_wr_data = 64'hFFFF_FC12_3456_789A;
        rd(ra(4), 9'h012);
        tick();
        mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
        tick();
        check_rsp("rd_pt_same", 9'h012, 64'h0000_0012_3456_789A);

        // VTP_MODE: enable level and single-cycle invalidate pulse
        wr(ra(3), 64'd3);
        check("mode_pulse", 64'(vtp_mode), 64'd3);
        tick();
        check("mode_after", 64'(vtp_mode), 64'd1);
        read_check("rd_mode", ra(3), 9'h013, 64'd1);
        mmio_wr_valid = 1'b1; mmio_wr_addr = ra(3); mmio_wr_data = 64'd2;
        tick();
        check("mode_b2b_a", 64'(vtp_mode), 64'd2);
        tick();
        mmio_wr_valid = 1'b0;
        check("mode_b2b_b", 64'(vtp_mode), 64'd2);
        tick();
        check("mode_b2b_c", 64'(vtp_mode), 64'd0);

        // Counters
        for (int i = 0; i < 10; i++) begin
            ev_4kb_hit = 1'b1;
            ev_pt_walk_busy = (i < 7);
            tick();
        end
        ev_4kb_hit = 1'b0; ev_pt_walk_busy = 1'b0;
        read_check("ctr_4kh",  ra(6),  9'h020, 64'd10);
        read_check("ctr_busy", ra(10), 9'h021, 64'd7);
        // event in the request cycle is included
        ev_4kb_miss = 1'b1;
        rd(ra(7), 9'h022);
        tick();
        ev_4kb_miss = 1'b0; mmio_rd_valid = 1'b0;
        tick();
        check_rsp("ctr_4km_same", 9'h022, 64'd1);
        // clear beats a concurrent event
        ev_4kb_hit = 1'b1;
        wr(ra(5), 64'd1);
        ev_4kb_hit = 1'b0;
        read_check("clr_4kh",  ra(6),  9'h023, 64'd0);
        read_check("clr_busy", ra(10), 9'h024, 64'd0);
        read_check("rd_clrreg", ra(5), 9'h025, 64'd0);

        // Wrap of the 8-bit counter build
        ev_2mb_miss = 1'b1;
        repeat (255) tick();
        ev_2mb_miss = 1'b0;
        read_check("wrap_255", ra(9), 9'h030, 64'd255);
        ev_2mb_miss = 1'b1;
        tick();
        ev_2mb_miss = 1'b0;
        read_check("wrap_0", ra(9), 9'h031, 64'd0);

        // WRO pass-through and reserved slot
        read_check("wro_wr",  ra(11), 9'h040, 64'h0000_0001_0000_0011);
        read_check("wro_rd",  ra(12), 9'h041, 64'h0000_0002_0000_0022);
        read_check("wro_wc",  ra(13), 9'h042, 64'h8000_0000_0000_0033);
        read_check("wro_rc",  ra(14), 9'h043, 64'h0000_0000_0000_0044);
        read_check("rsvd15",  ra(15), 9'h044, 64'd0);

        // Decode edges
        read_check("odd_rd",  ra(0) | 16'd1, 9'h1AB, 64'd0);
        read_check("out_rd",  16'h0000,      9'h1FF, 64'd0);
        wr(ra(0), 64'h1234);
        read_check("ro_dfh",  ra(0), 9'h050, DFH);
        wr(ra(4) | 16'd1, 64'h5);
        wr(16'h0008, 64'h7);
        check("pt_nochg", 64'(vtp_pt_base), 64'h0000_0012_3456_789A);

        // Reset with reads in flight drops them
        rd(ra(1), 9'd1);
        tick();
        rd(ra(2), 9'd2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_fl_rspv", 64'(mmio_rsp_valid), 64'd0);
        mmio_rd_valid = 1'b0;
        tick();
        tick();
        check("rst_ptval2", 64'(vtp_pt_base_valid), 64'd0);
        check("rst_mode2",  64'(vtp_mode),          64'd0);
        reset = 1'b0;
        rsp_seen = 0;
        repeat (4) begin
            tick();
            if (mmio_rsp_valid) rsp_seen++;
        end
        check("rst_fl_norsp", 64'(rsp_seen), 64'd0);
        read_check("rst_ctr", ra(7), 9'h060, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
